// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Byte-addressable data memory for the MIPS datapath. Supports byte, half
// and word loads/stores (little-endian, sign/zero extended loads), a
// valid/ready request handshake, a fixed READ_LAT response pipeline, error
// reporting for misaligned / reserved-size / out-of-range requests, and a
// zeroing sweep of the whole array after every reset.
//
// Ports
//   i_clk           clock, all state on rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid     request present
//   o_req_ready     controller accepts a request this cycle (READY state)
//   i_req_we        1 = store, 0 = load
//   i_req_size      0 = byte, 1 = half, 2 = word, 3 = reserved (error)
//   i_req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   i_req_addr      byte address
//   i_req_wdata     store data, byte/half taken from the low bits
//   o_rsp_valid     one-cycle pulse per accepted request
//   o_rsp_rdata     extended load result, 0 for stores and errors
//   o_rsp_err       error flag, qualified by o_rsp_valid
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err
);

   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [IDX_W-1:0]  r_initCnt;
   logic              w_initWe;
   logic              w_initDone;
   logic [31:0]       r_mem [DEPTH];

   logic [IDX_W-1:0]  w_wordIdx;
   logic [31:0]       w_wordIdx32;
   logic              w_sizeErr;
   logic              w_misaligned;
   logic              w_rangeErr;
   logic              w_err;
   logic              w_accept;
   logic              w_storeEn;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_wrData;
   logic [31:0]       w_rdWord;
   logic [31:0]       w_shifted;
   logic [31:0]       w_loadData;
   logic [31:0]       w_rspData;

   logic [READ_LAT-1:0] r_pipeVld;
   logic [READ_LAT-1:0] r_pipeErr;
   logic [31:0]         r_pipeData [READ_LAT];

   // State register: reset always restarts the zeroing sweep
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: leave INIT once the last word has been cleared
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         INIT:    if (w_initDone) w_nextState = READY;
         READY:   w_nextState = READY;
         default: w_nextState = INIT;
      endcase
   end

   // Output logic: requests are only taken once the sweep is finished
   always_comb begin
      o_req_ready = 1'b0;
      w_initWe    = 1'b0;
      case (r_state)
         INIT:    w_initWe    = 1'b1;
         READY:   o_req_ready = 1'b1;
         default: w_initWe    = 1'b0;
      endcase
   end

   assign w_initDone = (r_initCnt == IDX_W'(DEPTH - 1));

   // Sweep counter, one word per cycle while in INIT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_initCnt <= '0;
      end else if (w_initWe) begin
         r_initCnt <= r_initCnt + 1'b1;
      end
   end

   // Request decode: error classification, lane enables and load extraction
   always_comb begin
      w_wordIdx    = i_req_addr[ADDR_W-1:2];
      w_wordIdx32  = 32'(w_wordIdx);
      w_rangeErr   = (w_wordIdx32 >= 32'(DEPTH));
      w_sizeErr    = 1'b0;
      w_misaligned = 1'b0;
      w_byteEn     = 4'b0000;
      w_wrData     = i_req_wdata;
      w_rdWord     = r_mem[w_wordIdx];
      // Halves are only legal with addr[0]=0, so one byte-granular shift
      // brings either a byte or a half lane down to bit 0
      w_shifted    = w_rdWord >> {i_req_addr[1:0], 3'b000};
      w_loadData   = w_rdWord;
      case (i_req_size)
         2'd0: begin
            w_byteEn   = 4'b0001 << i_req_addr[1:0];
            w_wrData   = {4{i_req_wdata[7:0]}};
            w_loadData = i_req_unsigned ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
         end
         2'd1: begin
            w_misaligned = i_req_addr[0];
            w_byteEn     = i_req_addr[1] ? 4'b1100 : 4'b0011;
            w_wrData     = {2{i_req_wdata[15:0]}};
            w_loadData   = i_req_unsigned ? {16'h0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
         end
         2'd2: begin
            w_misaligned = |i_req_addr[1:0];
            w_byteEn     = 4'b1111;
         end
         default: begin
            w_sizeErr = 1'b1;
         end
      endcase
   end

   assign w_err     = w_sizeErr | w_misaligned | w_rangeErr;
   assign w_accept  = i_req_valid & o_req_ready;
   assign w_storeEn = w_accept & i_req_we & ~w_err;
   assign w_rspData = (w_err | i_req_we) ? 32'h0 : w_loadData;

   // Memory array: sweep writes have priority, stores write only enabled lanes
   always_ff @(posedge i_clk) begin
      if (w_initWe) begin
         r_mem[r_initCnt] <= '0;
      end else if (w_storeEn) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byteEn[b]) begin
               r_mem[w_wordIdx][8*b +: 8] <= w_wrData[8*b +: 8];
            end
         end
      end
   end

   // Response pipeline: data only advances behind a valid bit, so the last
   // stage keeps showing the most recent response between pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pipeVld <= '0;
         r_pipeErr <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            r_pipeData[i] <= '0;
         end
      end else begin
         r_pipeVld[0] <= w_accept;
         if (w_accept) begin
            r_pipeData[0] <= w_rspData;
            r_pipeErr[0]  <= w_err;
         end
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipeVld[i] <= r_pipeVld[i-1];
            if (r_pipeVld[i-1]) begin
               r_pipeData[i] <= r_pipeData[i-1];
               r_pipeErr[i]  <= r_pipeErr[i-1];
            end
         end
      end
   end

   assign o_rsp_valid = r_pipeVld[READ_LAT-1];
   assign o_rsp_rdata = r_pipeData[READ_LAT-1];
   assign o_rsp_err   = r_pipeErr[READ_LAT-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Self-checking bench for data_memory_ctrl (DEPTH=64, READ_LAT=3). A
// byte-array model of memory produces expected responses, which are queued
// with the edge at which the response pulse is due; every falling edge the
// outputs are compared against that queue and against the expected ready.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

   localparam int DEPTH    = 64;
   localparam int ADDR_W   = 8;
   localparam int READ_LAT = 3;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWe = 1'b0;
   logic [1:0]  reqSize = 2'd0;
   logic        reqUnsigned = 1'b0;
   logic [7:0]  reqAddr = 8'h00;
   logic [31:0] reqWdata = 32'h0;
   logic        rspValid;
   logic [31:0] rspRdata;
   logic        rspErr;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   rsp_t       expQ[$];
   vec_t       vecs[$];
   logic [7:0] modelMem [DEPTH*4];
   int         testsRun  = 0;
   int         failures  = 0;
   int         edgeCount = 0;
   int         relEdge   = 0;
   logic       inReset   = 1'b1;

   data_memory_ctrl #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_req_valid    (reqValid),
      .o_req_ready    (reqReady),
      .i_req_we       (reqWe),
      .i_req_size     (reqSize),
      .i_req_unsigned (reqUnsigned),
      .i_req_addr     (reqAddr),
      .i_req_wdata    (reqWdata),
      .o_rsp_valid    (rspValid),
      .o_rsp_rdata    (rspRdata),
      .o_rsp_err      (rspErr)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Rising-edge counter used to timestamp requests and responses
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Model says the controller is ready once DEPTH edges have passed since release
   function automatic logic modelReady();
      return !inReset && ((edgeCount - relEdge) >= DEPTH);
   endfunction

   // Reference memory: little-endian byte array with natural alignment rules
   function automatic void modelAccess(input logic we, input logic [1:0] size,
                                       input logic uns, input logic [7:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
      int a;
      int nBytes;
      a      = int'(addr);
      nBytes = 1 << size;
      err    = (size == 2'd3) || ((a % nBytes) != 0);
      rdata  = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < nBytes; i++) modelMem[a+i] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < nBytes; i++) rdata = rdata | (32'(modelMem[a+i]) << (8*i));
            if (!uns && nBytes < 4 && rdata[8*nBytes-1]) rdata = rdata | (32'hFFFF_FFFF << (8*nBytes));
         end
      end
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edgeCount);
      end
   endtask

   // Per-cycle check of ready and of any response pulse against the queue
   task automatic checkOutput();
      rsp_t r;
      checkVal("req_ready", 32'(reqReady), 32'(modelReady()));
      if (rspValid === 1'b1) begin
         if (expQ.size() == 0 || expQ[0].due != edgeCount) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL rsp_valid: unexpected pulse at edge %0d, next due %0d", edgeCount,
                     (expQ.size() == 0) ? -1 : expQ[0].due);
         end else begin
            r = expQ.pop_front();
            checkVal("rsp_rdata", rspRdata, r.rdata);
            checkVal("rsp_err", 32'(rspErr), 32'(r.err));
         end
      end else if (rspValid !== 1'b0) begin
         checkVal("rsp_valid_known", 32'(rspValid), 32'h0);
      end else if (expQ.size() != 0 && expQ[0].due <= edgeCount) begin
         testsRun++;
         failures++;
         $display("[TB] FAIL rsp_valid: missing pulse due at edge %0d, got 0 required 1", expQ[0].due);
         void'(expQ.pop_front());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      checkOutput();
   endtask

   // Idle cycle with random ignored payload
   task automatic idle();
      tick();
      reqValid    = 1'b0;
      reqWe       = 1'($urandom_range(0, 1));
      reqSize     = 2'($urandom_range(0, 3));
      reqUnsigned = 1'($urandom_range(0, 1));
      reqAddr     = 8'($urandom_range(0, 255));
      reqWdata    = $urandom;
   endtask

   // Issue one request; expectation comes from the table or from the model
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic useExp, input logic [31:0] expR, input logic expE);
      rsp_t        r;
      logic [31:0] mR;
      logic        mE;
      tick();
      reqValid    = 1'b1;
      reqWe       = we;
      reqSize     = size;
      reqUnsigned = uns;
      reqAddr     = addr;
      reqWdata    = wdata;
      modelAccess(we, size, uns, addr, wdata, mR, mE);
      r.due   = edgeCount + READ_LAT;
      r.rdata = useExp ? expR : mR;
      r.err   = useExp ? expE : mE;
      expQ.push_back(r);
   endtask

   task automatic drain();
      repeat (READ_LAT + 2) idle();
      checkVal("drain_pending", 32'(expQ.size()), 32'h0);
      expQ.delete();
   endtask

   // Assert reset, check the asynchronous clear, release and restart the model
   task automatic applyReset();
      tick();
      reqValid = 1'b0;
      rstN     = 1'b0;
      inReset  = 1'b1;
      expQ.delete();
      #1;
      checkVal("reset_rsp_valid", 32'(rspValid), 32'h0);
      checkVal("reset_rsp_rdata", rspRdata, 32'h0);
      checkVal("reset_rsp_err", 32'(rspErr), 32'h0);
      checkVal("reset_req_ready", 32'(reqReady), 32'h0);
      repeat (2) tick();
      rstN    = 1'b1;
      inReset = 1'b0;
      relEdge = edgeCount;
      for (int i = 0; i < DEPTH*4; i++) modelMem[i] = 8'h00;
   endtask

   // Wait out the sweep while offering stores that must be ignored
   task automatic waitReady();
      for (int n = 0; n < DEPTH + 4; n++) begin
         tick();
         if (modelReady()) begin
            reqValid = 1'b0;
            return;
         end
         reqValid = 1'b1;
         reqWe    = 1'b1;
         reqSize  = 2'd2;
         reqAddr  = 8'h00;
         reqWdata = 32'hDEAD_BEEF;
      end
   endtask

   task automatic addVec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expR, input logic expE);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.expRdata = expR; v.expErr = expE;
      vecs.push_back(v);
   endtask

   initial begin
      logic        rWe;
      logic [1:0]  rSize;
      logic        rUns;
      logic [7:0]  rAddr;
      logic [7:0]  mask;
      int          pick;

      // Directed vectors, issued back-to-back
      addVec(0, 2'd2, 0, 8'h00, 32'h0,         32'h0000_0000, 0);
      addVec(1, 2'd2, 0, 8'h10, 32'h8BAD_F00D, 32'h0000_0000, 0);
      addVec(0, 2'd0, 0, 8'h10, 32'h0,         32'h0000_000D, 0);
      addVec(0, 2'd0, 0, 8'h11, 32'h0,         32'hFFFF_FFF0, 0);
      addVec(0, 2'd0, 0, 8'h12, 32'h0,         32'hFFFF_FFAD, 0);
      addVec(0, 2'd0, 0, 8'h13, 32'h0,         32'hFFFF_FF8B, 0);
      addVec(0, 2'd0, 1, 8'h13, 32'h0,         32'h0000_008B, 0);
      addVec(1, 2'd0, 0, 8'h11, 32'hAAAA_AA5A, 32'h0000_0000, 0);
      addVec(0, 2'd2, 0, 8'h10, 32'h0,         32'h8BAD_5A0D, 0);
      addVec(1, 2'd1, 0, 8'h12, 32'h7777_1234, 32'h0000_0000, 0);
      addVec(0, 2'd2, 1, 8'h10, 32'h0,         32'h1234_5A0D, 0);
      addVec(0, 2'd1, 0, 8'h12, 32'h0,         32'h0000_1234, 0);
      addVec(1, 2'd1, 0, 8'h10, 32'h0000_BEEF, 32'h0000_0000, 0);
      addVec(0, 2'd1, 0, 8'h10, 32'h0,         32'hFFFF_BEEF, 0);
      addVec(0, 2'd1, 1, 8'h10, 32'h0,         32'h0000_BEEF, 0);
      addVec(0, 2'd0, 0, 8'h11, 32'h0,         32'hFFFF_FFBE, 0);
      addVec(0, 2'd2, 0, 8'h10, 32'h0,         32'h1234_BEEF, 0);
      addVec(1, 2'd2, 0, 8'h20, 32'hCAFE_F00D, 32'h0000_0000, 0);
      addVec(1, 2'd1, 0, 8'h21, 32'h0000_FFFF, 32'h0000_0000, 1);
      addVec(0, 2'd2, 0, 8'h22, 32'h0,         32'h0000_0000, 1);
      addVec(0, 2'd3, 0, 8'h24, 32'h0,         32'h0000_0000, 1);
      addVec(1, 2'd3, 0, 8'h20, 32'h1111_1111, 32'h0000_0000, 1);
      addVec(1, 2'd2, 0, 8'h22, 32'h2222_2222, 32'h0000_0000, 1);
      addVec(0, 2'd2, 0, 8'h20, 32'h0,         32'hCAFE_F00D, 0);

      applyReset();
      waitReady();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                       1'b1, vecs[i].expRdata, vecs[i].expErr);
      end
      drain();

      // Back-to-back store/load/load through the three-stage pipeline
      applyStimulus(1, 2'd2, 0, 8'h08, 32'h0000_0007, 1'b1, 32'h0, 1'b0);
      drain();
      applyStimulus(1, 2'd2, 0, 8'h04, 32'h0BAD_CAFE, 1'b1, 32'h0, 1'b0);
      applyStimulus(0, 2'd2, 0, 8'h04, 32'h0,         1'b1, 32'h0BAD_CAFE, 1'b0);
      applyStimulus(0, 2'd2, 0, 8'h08, 32'h0,         1'b1, 32'h0000_0007, 1'b0);
      drain();

      // Reset with two loads in flight: responses dropped, stores wiped
      applyStimulus(1, 2'd2, 0, 8'h40, 32'h55AA_55AA, 1'b1, 32'h0, 1'b0);
      applyStimulus(0, 2'd2, 0, 8'h40, 32'h0,         1'b1, 32'h55AA_55AA, 1'b0);
      drain();
      applyStimulus(0, 2'd2, 0, 8'h40, 32'h0, 1'b1, 32'h55AA_55AA, 1'b0);
      applyStimulus(0, 2'd0, 0, 8'h41, 32'h0, 1'b1, 32'h0000_0055, 1'b0);
      applyReset();
      waitReady();
      applyStimulus(0, 2'd2, 0, 8'h40, 32'h0, 1'b1, 32'h0, 1'b0);
      applyStimulus(0, 2'd2, 0, 8'h10, 32'h0, 1'b1, 32'h0, 1'b0);
      applyStimulus(0, 2'd2, 0, 8'h04, 32'h0, 1'b1, 32'h0, 1'b0);
      drain();

      // Random traffic against the byte-array model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else begin
            rWe  = 1'($urandom_range(0, 1));
            rUns = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            rSize = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
            rAddr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 63))
                                                : 8'($urandom_range(0, 255));
            if (rSize != 2'd3 && $urandom_range(0, 3) != 0) begin
               mask  = 8'((1 << rSize) - 1);
               rAddr = rAddr & ~mask;
            end
            applyStimulus(rWe, rSize, rUns, rAddr, $urandom, 1'b0, 32'h0, 1'b0);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressable data memory for the single-cycle/multi-cycle MIPS datapath; successor to the fixed 64-word word-only data memory.
- Adds byte/halfword/word stores and loads (sign/zero extension), configurable read latency, valid/ready request handshake, misalignment and range error reporting, and a post-reset zero-initialisation sweep.
- Sits between the datapath load/store unit and the write-back mux.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096.
- ADDR_W, 8, byte-address width; must equal log2(DEPTH)+2.
- READ_LAT, 1, response latency in cycles, 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; byte/half taken from the low bits
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  load result (extended); 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; misaligned, reserved size, or out of range

Behaviour:
- Reset (async, rst_n low): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, response pipeline flushed, FSM to INIT, init counter=0. Memory contents are undefined until INIT completes.
- FSM INIT: one word written to 0 per cycle, counter 0..DEPTH-1; req_ready=0. After writing word DEPTH-1, go to READY. INIT takes exactly DEPTH cycles after rst_n deasserts.
- FSM READY: req_ready=1 every cycle; no backpressure on responses. One request per cycle max.
- Acceptance: req_valid & req_ready at a rising edge. Inputs are ignored otherwise.
- Word index = req_addr[ADDR_W-1:2]. Little-endian: lane = req_addr[1:0] for bytes, req_addr[1] for halves.
- Errors: size=1 with addr[0]=1; size=2 with addr[1:0]!=0; size=3. Errored stores do not modify memory. Errored responses return rsp_rdata=0, rsp_err=1. Out of range cannot occur when ADDR_W is correctly set; the controller checks it anyway and flags it.
- Store: write enable per byte lane. Byte writes req_wdata[7:0] into the addressed lane. Half writes req_wdata[15:0] into lanes 1:0 or 3:2. Other lanes are unchanged. Memory updates at the accepting edge. The response has rsp_rdata=0, rsp_err=0.
- Load: the addressed lane(s) are extracted and extended to 32 bits per req_unsigned; req_unsigned is ignored for words.
- Latency: a request accepted at edge k gives rsp_valid=1 for exactly the cycle after edge k+READ_LAT-1. Responses are in order; back-to-back requests give back-to-back responses.
- Read-after-write: a load accepted the cycle after a store to the same word sees the new data. Data is read from the array at the acceptance edge, after the prior edge's write.
- rsp_rdata/rsp_err hold their last values when rsp_valid=0. The bench checks them only when rsp_valid=1.
- Reset mid-operation: in-flight responses are discarded (no rsp_valid), INIT restarts from 0, and stores already committed are overwritten by the sweep.

Test Plan:
- Reset release, DEPTH=64 -> req_ready low for exactly 64 cycles, then high. A word load of 0x00 returns 0x00000000, err=0, after READ_LAT.
- Store word 0x8badf00d @0x10; load bytes @0x10..0x13, signed -> 0x0000000d, 0xfffffff0, 0xffffffad, 0xffffff8b. Unsigned @0x13 -> 0x0000008b.
- Store byte 0x5a @0x11 over 0x8badf00d -> word load @0x10 = 0x8bad5a0d. Store half 0x1234 @0x12 -> 0x12345a0d. Signed half load @0x12 -> 0x00001234.
- Misaligned: half store @0x21, word load @0x22, size=3 @0x24 -> each response err=1, rdata=0. Word @0x20 is unchanged afterwards.
- READ_LAT=3: back-to-back store @0x04, load @0x04, load @0x08 (pre-stored 7) -> three consecutive rsp_valid pulses starting 3 cycles after the first accept, carrying 0, store data, and 7.
- rst_n pulsed low while two loads are in flight -> no rsp_valid, INIT restarts, and previously stored words read 0 after INIT.
